// File: rtl/dma_pkg.sv
// Shared encodings for the DMA engine: FSM states, register map and bit positions.
// Used by dma_regs and dma_engine; the timeout feature is DMA_TIMEOUT_EN in dma_engine.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_FIN     = 3'd6
  } dma_state_t;

  // Register index as seen on bus a[4:2]
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_REMAIN = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_TMO  = 3;

  // Mapper slot: a[31:24]==0x9d selects this block (0x9c is the neighbouring slot)
  localparam logic [7:0]  DMA_SLOT  = 8'h9d;
  localparam logic [31:0] DMA_BASE  = {DMA_SLOT, 24'h000000};

endpackage

// File: rtl/dma_regs.sv
// MMIO register file of the DMA engine: SRC/DST/LEN/CTRL/STATUS/REMAIN,
// start/abort pulse decode and the combinational read mux.
module dma_regs
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       i_a,
  input  logic [31:0]      i_d,
  input  logic             i_we,
  input  logic             i_step,
  input  logic             i_fin,
  input  logic             i_fin_err,
  input  logic             i_fin_tmo,
  output logic             o_start,
  output logic             o_abort,
  output logic [31:0]      o_src,
  output logic [31:0]      o_dst,
  output logic [LEN_W-1:0] o_remain,
  output logic [31:0]      o_spo,
  output logic             o_irq
);

  logic [29:0]      r_src;
  logic [29:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remain;
  logic             r_irq_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_tmo;

  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_start_req;
  logic w_start_zero;

  assign w_wr_ctrl    = i_we && (i_a == REG_CTRL);
  assign w_wr_status  = i_we && (i_a == REG_STATUS);
  assign w_start_req  = w_wr_ctrl && i_d[CTRL_START] && !r_busy;
  assign o_start      = w_start_req && (r_len != '0);
  assign w_start_zero = w_start_req && (r_len == '0);
  assign o_abort      = w_wr_ctrl && i_d[CTRL_ABORT] && r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_remain <= '0;
      r_irq_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      if (i_we && !r_busy) begin
        case (i_a)
          REG_SRC: r_src <= i_d[31:2];
          REG_DST: r_dst <= i_d[31:2];
          REG_LEN: r_len <= i_d[LEN_W-1:0];
          default: ;
        endcase
      end
      if (w_wr_ctrl) r_irq_en <= i_d[CTRL_IRQ_EN];
      if (i_step) begin
        r_src    <= r_src + 30'd1;
        r_dst    <= r_dst + 30'd1;
        r_remain <= r_remain - LEN_W'(1);
      end
      if (o_start) begin
        r_busy   <= 1'b1;
        r_remain <= r_len;
      end
      // Clears come first so a same-cycle completion overrides them
      if (w_wr_status) begin
        if (i_d[ST_DONE]) r_done <= 1'b0;
        if (i_d[ST_ERR]) begin
          r_err <= 1'b0;
          r_tmo <= 1'b0;
        end
      end
      if (w_start_zero) r_done <= 1'b1;
      if (i_fin) begin
        r_busy <= 1'b0;
        if (i_fin_err) r_err  <= 1'b1;
        else           r_done <= 1'b1;
        if (i_fin_tmo) r_tmo  <= 1'b1;
      end
    end
  end

  always_comb begin
    o_spo = '0;
    case (i_a)
      REG_SRC:    o_spo = {r_src, 2'b00};
      REG_DST:    o_spo = {r_dst, 2'b00};
      REG_LEN:    o_spo = 32'(r_len);
      REG_CTRL:   o_spo[CTRL_IRQ_EN] = r_irq_en;
      REG_STATUS: begin
        o_spo[ST_BUSY] = r_busy;
        o_spo[ST_DONE] = r_done;
        o_spo[ST_ERR]  = r_err;
        o_spo[ST_TMO]  = r_tmo;
      end
      REG_REMAIN: o_spo = 32'(r_remain);
      default:    o_spo = '0;
    endcase
  end

  assign o_src    = {r_src, 2'b00};
  assign o_dst    = {r_dst, 2'b00};
  assign o_remain = r_remain;
  assign o_irq    = r_irq_en && (r_done || r_err);

endmodule

// File: rtl/dma_engine.sv
// Word-granular memory-to-memory DMA: bus initiator FSM plus MMIO slave (dma_regs).
// Define DMA_TIMEOUT_EN to bound each WAIT state by TIMEOUT_CYCLES (STATUS bit3).
module dma_engine
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
`ifdef DMA_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dma_a,
  input  logic [31:0] dma_d,
  input  logic        dma_we,
  output logic [31:0] dma_spo,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] m_a,
  output logic [31:0] m_d,
  output logic        m_we,
  output logic        m_rd,
  input  logic [31:0] m_spo,
  input  logic        m_ready,
  input  logic        m_irq,
  output logic        irq,
  output dma_state_t  o_dbg_state
);

  // Initiator handshake: m_rd/m_we pulse for exactly the one REQ cycle with
  // m_a/m_d valid; the transaction completes on the first WAIT cycle with
  // m_ready=1, and m_a/m_d hold until that cycle ends.

  dma_state_t       r_state;
  dma_state_t       w_next;
  logic             w_start;
  logic             w_abort_pulse;
  logic             w_abort;
  logic             w_step;
  logic             w_fin;
  logic             w_tmo;
  logic             w_set_fail;
  logic             w_last;
  logic             r_abort_pend;
  logic             r_fail;
  logic             r_tmo_hit;
  logic [31:0]      r_data;
  logic [31:0]      w_src;
  logic [31:0]      w_dst;
  logic [LEN_W-1:0] w_remain;

  dma_regs #(
    .LEN_W (LEN_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .i_a       (dma_a),
    .i_d       (dma_d),
    .i_we      (dma_we),
    .i_step    (w_step),
    .i_fin     (w_fin),
    .i_fin_err (r_fail),
    .i_fin_tmo (r_tmo_hit),
    .o_start   (w_start),
    .o_abort   (w_abort_pulse),
    .o_src     (w_src),
    .o_dst     (w_dst),
    .o_remain  (w_remain),
    .o_spo     (dma_spo),
    .o_irq     (irq)
  );

  assign w_abort = r_abort_pend || w_abort_pulse;
  assign w_last  = (w_remain == LEN_W'(1));
  assign w_step  = (r_state == S_WR_WAIT) && m_ready;
  assign w_fin   = (r_state == S_FIN);

`ifdef DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_in_wait;

  assign w_in_wait = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_RD_REQ) || (r_state == S_WR_REQ)) begin
      r_tmo_cnt <= '0;
    end else if (w_in_wait && !m_ready) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without m_ready
  assign w_tmo = w_in_wait && !m_ready && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_set_fail = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_ARB;
      S_ARB: begin
        if (w_abort) begin
          w_next     = S_FIN;
          w_set_fail = 1'b1;
        end else if (bus_gnt) begin
          w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (m_irq) begin
          w_next     = S_FIN;
          w_set_fail = 1'b1;
        end else begin
          w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_tmo) begin
          w_next     = S_FIN;
          w_set_fail = 1'b1;
        end else if (m_ready) begin
          if (w_abort) begin
            w_next     = S_FIN;
            w_set_fail = 1'b1;
          end else begin
            w_next = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (m_irq) begin
          w_next     = S_FIN;
          w_set_fail = 1'b1;
        end else begin
          w_next = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (w_tmo) begin
          w_next     = S_FIN;
          w_set_fail = 1'b1;
        end else if (m_ready) begin
          if (w_abort) begin
            w_next     = S_FIN;
            w_set_fail = 1'b1;
          end else if (w_last) begin
            w_next = S_FIN;
          end else begin
            w_next = S_RD_REQ;
          end
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-transfer flags live only between start and FIN; IDLE wipes them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abort_pend <= 1'b0;
      r_fail       <= 1'b0;
      r_tmo_hit    <= 1'b0;
      r_data       <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_abort_pend <= 1'b0;
        r_fail       <= 1'b0;
        r_tmo_hit    <= 1'b0;
      end else begin
        if (w_abort_pulse) r_abort_pend <= 1'b1;
        if (w_set_fail)    r_fail       <= 1'b1;
        if (w_tmo)         r_tmo_hit    <= 1'b1;
      end
      if ((r_state == S_RD_WAIT) && m_ready) r_data <= m_spo;
    end
  end

  // Reset gates the strobes combinationally so they drop in the reset cycle itself
  always_comb begin
    bus_req = 1'b0;
    m_rd    = 1'b0;
    m_we    = 1'b0;
    m_a     = '0;
    m_d     = '0;
    if (!rst) begin
      case (r_state)
        S_ARB, S_FIN: bus_req = 1'b1;
        S_RD_REQ: begin
          bus_req = 1'b1;
          m_rd    = 1'b1;
          m_a     = w_src;
        end
        S_RD_WAIT: begin
          bus_req = 1'b1;
          m_a     = w_src;
        end
        S_WR_REQ: begin
          bus_req = 1'b1;
          m_we    = 1'b1;
          m_a     = w_dst;
          m_d     = r_data;
        end
        S_WR_WAIT: begin
          bus_req = 1'b1;
          m_a     = w_dst;
          m_d     = r_data;
        end
        default: ;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/dma_engine.md
# dma_engine

Word-granular memory-to-memory copy engine that acts as a bus initiator on the same a/d/we/rd/spo/ready protocol the CPU drives into the address mapper, plus a small MMIO register slave mapped at 0x9d000000. Software programs source, destination and length, then starts the engine. The engine requests the bus through a req/gnt pair, copies by alternating read and write transactions, and raises a level interrupt when it finishes or aborts.

## Interface
- TIMEOUT_CYCLES, 1024, wait-state limit per transaction (only with DMA_TIMEOUT_EN)
- LEN_W, 16, width of the word-count register
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dma_a  in  3  register select (bus a[4:2])
- dma_d  in  32  register write data
- dma_we  in  1  register write strobe
- dma_spo  out  32  register read data (combinational)
- bus_req  out  1  request bus ownership
- bus_gnt  in  1  ownership granted (arbiter holds while bus_req high)
- m_a  out  32  initiator address
- m_d  out  32  initiator write data
- m_we  out  1  write request pulse
- m_rd  out  1  read request pulse
- m_spo  in  32  read data
- m_ready  in  1  target ready
- m_irq  in  1  mapper unmapped-address flag
- irq  out  1  completion interrupt (level)

## Operation
- Registers: 0 SRC, 1 DST, 2 LEN (words, LEN_W bits), 3 CTRL (bit0 start, write-1 pulse; bit1 irq_en; bit2 abort, write-1 pulse), 4 STATUS (bit0 busy, bit1 done, bit2 err; write 1 to bit1/bit2 clears), 5 REMAIN (read-only). SRC/DST bits [1:0] always read 0.
- SRC/DST/LEN writes are ignored while busy. Start is ignored while busy.
- Start with LEN=0: done=1 on the next cycle, no bus traffic.
- FSM: IDLE -> ARB (bus_req=1) -> on bus_gnt RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> if REMAIN==0 FIN, else RD_REQ. FIN -> IDLE.
- bus_req stays high from ARB through FIN.
- REQ states: m_rd or m_we is high for exactly that one cycle, with m_a/m_d valid. m_a/m_d stay stable until the WAIT state exits.
- WAIT states: exit on the first cycle with m_ready=1. In RD_WAIT, m_spo is captured into a data latch on that cycle.
- After each write completes: SRC+=4, DST+=4 (mod 2^32), REMAIN-=1.
- m_irq=1 in any REQ cycle: go to FIN with err=1, REMAIN unchanged, and no write for a failed read.
- Abort: takes effect at the next WAIT exit or in ARB, then FIN with err=1. It never cuts a pending transaction.
- FIN sets done (unless err), clears busy, and drops bus_req.
- irq = irq_en & (done | err).
- Simultaneous status clear and a new done/err in the same cycle: the set wins.

## Timing
- Reset values: all outputs 0, registers 0, FSM IDLE.
- Reset mid-transfer: returns to IDLE the next cycle and drops bus_req and m_we/m_rd immediately.
- Register write takes effect on the next clock. dma_spo reflects current register state combinationally.
- With zero-wait targets (m_ready=1 always), one word costs 4 cycles (RD_REQ, RD_WAIT, WR_REQ, WR_WAIT).
- A transfer of N words takes 1 (ARB, with gnt already high) + 4N + 1 (FIN) cycles from the start write to done.

## Configuration
- DMA_TIMEOUT_EN defined: a counter clears on each REQ cycle and increments in WAIT. Reaching TIMEOUT_CYCLES forces FIN with err=1 and STATUS bit3 (tmo)=1.
- DMA_TIMEOUT_EN undefined: WAIT states wait forever and bit3 reads 0.

## Structure
- Package dma_pkg holds: FSM state encoding, register index constants (SRC..REMAIN), STATUS/CTRL bit positions, the 0x9c/0x9d mapper slot constant.
- Sub-module dma_regs holds the register file, the start/abort pulse decode and the dma_spo mux. The top level keeps the FSM and the initiator datapath.

## Test plan
- SRC=0x10000000, DST=0x10000100, LEN=4, zero-wait memory -> 4 reads then 4 writes alternating, DST words equal SRC words, done at cycle 18, REMAIN=0.
- Same transfer with m_ready held low 3 cycles on each access -> m_a stable throughout, m_rd/m_we single-cycle pulses, data correct.
- SRC=0x30000000 (mapper m_irq=1) -> err=1 after the first RD_REQ, no m_we ever, irq high when irq_en=1.
- Abort written during the 2nd word's RD_WAIT -> that read completes, no write follows, err=1, REMAIN=3.
- LEN=0 start -> done the next cycle, bus_req never asserted. Start while busy -> ignored.
- DMA_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_ready stuck low -> err=1 and tmo=1 after 8 wait cycles. Reset mid-transfer -> all outputs 0 the next cycle.
